// File: rtl/fp_align_addsub.sv
// Front end of the binary32 adder/subtractor: unpack, swap, align and magnitude add/sub.
// Two-stage valid/ready pipeline with full backpressure; specials collapse to a fixed NaN marker.
module fp_align_addsub (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign,
    output logic [7:0]  pre_E,
    output logic [23:0] pre_M,
    output logic        OV,
    output logic        op
);

    logic        adv1, adv2;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        a_big, special, b_sign_eff;

    logic        s1_valid, s1_sign, s1_eop, s1_special;
    logic [7:0]  s1_e, s1_d;
    logic [23:0] s1_ml, s1_ms;

    logic [23:0] ms_al;
    logic [24:0] sum;
    logic        nxt_sign;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        ea         = A[30:23];
        eb         = B[30:23];
        ma         = (ea != 8'd0) ? {1'b1, A[22:0]} : 24'd0;
        mb         = (eb != 8'd0) ? {1'b1, B[22:0]} : 24'd0;
        b_sign_eff = B[31] ^ sub;
        a_big      = (ea > eb) || ((ea == eb) && (ma >= mb));
        special    = (ea == 8'hFF) || (eb == 8'hFF);
    end

    // NOTE: sequential state uses non-blocking assignments so both stages sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_eop     <= 1'b0;
            s1_special <= 1'b0;
            s1_e       <= 8'd0;
            s1_d       <= 8'd0;
            s1_ml      <= 24'd0;
            s1_ms      <= 24'd0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_eop     <= sub ^ A[31] ^ B[31];
                s1_special <= special;
                s1_sign    <= a_big ? A[31] : b_sign_eff;
                s1_e       <= a_big ? ea : eb;
                s1_d       <= a_big ? (ea - eb) : (eb - ea);
                s1_ml      <= a_big ? ma : mb;
                s1_ms      <= a_big ? mb : ma;
            end
        end
    end

    // Alignment drops shifted-out bits; there is no guard/round/sticky.
    always_comb begin
        ms_al    = (s1_d >= 8'd24) ? 24'd0 : (s1_ms >> s1_d);
        sum      = s1_eop ? ({1'b0, s1_ml} - {1'b0, ms_al})
                          : ({1'b0, s1_ml} + {1'b0, ms_al});
        nxt_sign = (s1_eop && (sum[23:0] == 24'd0)) ? 1'b0 : s1_sign;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sign      <= 1'b0;
            pre_E     <= 8'd0;
            pre_M     <= 24'd0;
            OV        <= 1'b0;
            op        <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                if (s1_special) begin
                    sign  <= 1'b0;
                    pre_E <= 8'hFF;
                    pre_M <= 24'hC00000;
                    OV    <= 1'b0;
                    op    <= 1'b0;
                end else begin
                    sign  <= nxt_sign;
                    pre_E <= s1_e;
                    pre_M <= sum[23:0];
                    OV    <= s1_eop ? 1'b0 : sum[24];
                    op    <= s1_eop;
                end
            end
        end
    end

endmodule

// File: doc/fp_align_addsub.md
# fp_align_addsub

Pipelined front end of the single-precision adder/subtractor. It accepts two IEEE-754 binary32 operands and an add/sub command. It unpacks and compares the operands, aligns the smaller mantissa, and performs the magnitude add or subtract. It delivers `pre_E`, `pre_M`, `OV`, `op` and the result sign to the normalize/adjust stage directly downstream. It is a two-stage valid/ready pipeline with full backpressure.

## Interface
Parameters:
- none (binary32 only; all widths fixed)

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operand set `A`, `B`, `sub` is valid
- `in_ready`  out  1  block accepts the input this cycle
- `A`  in  32  operand A (binary32)
- `B`  in  32  operand B (binary32)
- `sub`  in  1  0 = A+B, 1 = A−B
- `out_valid`  out  1  output bundle valid
- `out_ready`  in  1  downstream consumes the bundle this cycle
- `sign`  out  1  result sign
- `pre_E`  out  8  exponent of the larger-magnitude operand
- `pre_M`  out  24  magnitude result bits [23:0], hidden bit at [23]
- `OV`  out  1  carry out (bit 24) of the magnitude addition
- `op`  out  1  effective operation: 0 = magnitude add, 1 = magnitude subtract

## Operation
- Unpack:
  - `e = X[30:23]`.
  - If `e != 0`, `m = {1, X[22:0]}`.
  - If `e == 0`, the operand is flushed to zero: `m = 0`, exponent treated as 0.
- Effective op: `eop = sub ^ A[31] ^ B[31]`. `Bs = B[31] ^ sub` is the effective sign of B.
- Swap:
  - L (larger) is the operand with the larger exponent.
  - If exponents are equal, L is the one with the larger `m`.
  - If both exponent and `m` are equal, L = A.
  - S is the other operand.
- Align:
  - `d = eL − eS` (8-bit, never negative).
  - `mS_al = mS >> d`. If `d >= 24`, `mS_al = 0`.
  - Shifted-out bits are discarded: no guard/round/sticky bits.
- Arithmetic:
  - If `eop = 0`: `{OV, pre_M} = mL + mS_al` (25-bit).
  - If `eop = 1`: `pre_M = mL − mS_al`, which is never negative, and `OV = 0`.
- Outputs:
  - `pre_E = eL`, `op = eop`.
  - `sign` = sign of L (A's sign, or `Bs` when L = B).
  - When `eop = 1` and `pre_M = 0`, `sign = 0`.
- Specials: if either exponent is 8'hFF, the output is forced to `pre_E = 8'hFF`, `pre_M = 24'hC00000`, `OV = 0`, `op = 0`, `sign = 0`. The downstream stage then produces a NaN pattern. Inf and NaN are not distinguished.
- Pipeline stages:
  - Stage 1 registers the unpack, swap, `d`, sign and `eop` results.
  - Stage 2 performs the align and add/sub and registers the outputs.

## Timing
- Latency: 2 cycles from input acceptance (`in_valid && in_ready`) to `out_valid`, when `out_ready` is held high.
- Throughput: 1 operation per cycle when `out_ready` is held high.
- Handshake:
  - Stage 2 advances when `!out_valid || out_ready`.
  - Stage 1 advances when stage 1 is empty or stage 2 advances.
  - `in_ready` = stage-1 advance condition. It is combinational from `out_ready` and the valid bits.
- While `out_valid && !out_ready`, all outputs hold stable.
- Maximum 2 operations in flight. `in_ready` falls only when both stages are full and `out_ready = 0`.
- Reset:
  - All valid bits clear. `out_valid = 0`, `in_ready = 1` in the cycle after reset.
  - `sign`, `pre_E`, `pre_M`, `OV`, `op` all reset to 0.
  - Reset asserted mid-operation discards in-flight data. Nothing is emitted afterwards from pre-reset inputs.
  - Inputs presented while `rst = 1` are ignored.
- Ordering: outputs appear in acceptance order, with no drops or duplicates under any `out_ready` pattern.

## Test plan
- 3F800000 + 3F800000 (1.0 + 1.0), `sub = 0`, `out_ready = 1` → two cycles later: `pre_E = 7F`, `pre_M = 000000`, `OV = 1`, `op = 0`, `sign = 0`.
- 3F800000 − 40400000 (1.0 − 3.0) → `pre_E = 80`, `pre_M = 800000`, `OV = 0`, `op = 1`, `sign = 1`. 3FC00000 − 3F800000 → `pre_E = 7F`, `pre_M = 400000`, `op = 1`, `sign = 0`.
- 3F800000 + 30800000 (`d = 30`) → `pre_M = 800000`, `pre_E = 7F`, `OV = 0`. 3F800000 + 3F000000 (`d = 1`) → `pre_M = C00000`.
- 40400000 − 40400000 → `pre_M = 000000`, `op = 1`, `sign = 0`. 7F800000 + 3F800000 → `pre_E = FF`, `pre_M = C00000`, `op = 0`.
- Backpressure: 4 back-to-back inputs with `out_ready = 0` for 5 cycles:
  - `in_ready` drops after 2 acceptances.
  - Outputs stay stable while stalled.
  - After release, all 4 results emerge in order, one per cycle.
- Reset mid-flight: accept 2 ops, assert `rst` for 1 cycle → `out_valid = 0`, all outputs 0, no stale result emitted. A new op then completes in exactly 2 cycles.
